fifo_tx_packetizer: RTL and testbench

//   Read-side master for fifo_ram_module: drains buffered bytes and hands them one at a time
//   to the UART transmitter feeding the RF module, framed as packets of at most MAX_PKT bytes.
//   A packet starts when the FIFO reaches its limit or holds data for IDLE_TIMEOUT cycles

---
 rtl/fifo_tx_packetizer.sv | 165 ++++++++++++++++
 tb/tb_fifo_tx_packetizer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_packetizer.sv
// fifo_tx_packetizer: read-side master for fifo_ram_module.
// Drains buffered bytes one at a time into the UART transmitter that feeds the
// RF module, framing them as packets of at most MAX_PKT bytes. A packet starts
// when the FIFO hits its limit, or has held data below the limit for
// IDLE_TIMEOUT cycles, and only while the radio AUX line reports ready.
module fifo_tx_packetizer #(
   parameter int WIDTH        = 8,
   parameter int MAX_PKT      = 58,
   parameter int IDLE_TIMEOUT = 1000,
   parameter int RD_LATENCY   = 1,
   parameter int GAP_CYCLES   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable_i,
   input  logic                         fifo_empty_i,
   input  logic                         fifo_limit_i,
   input  logic [WIDTH-1:0]             fifo_data_i,
   output logic                         fifo_rd_o,
   input  logic                         aux_ready_i,
   output logic [WIDTH-1:0]             tx_data_o,
   output logic                         tx_valid_o,
   input  logic                         tx_ready_i,
   output logic                         pkt_active_o,
   output logic                         pkt_done_o,
   output logic [$clog2(MAX_PKT+1)-1:0] byte_cnt_o
);

   localparam int CNT_W  = $clog2(MAX_PKT + 1);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam int LAT_W  = $clog2(RD_LATENCY + 1);
   // gap counter only has to reach GAP_CYCLES-1
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  PKT_MAX  = CNT_W'(MAX_PKT);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
   localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(RD_LATENCY);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT_DATA,
      S_SEND,
      S_PKT_END,
      S_GAP
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [IDLE_W-1:0]  r_idle_cnt;
   logic [LAT_W-1:0]   r_lat_cnt;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [CNT_W-1:0]   r_byte_cnt;
   logic [WIDTH-1:0]   r_tx_data;
   logic               r_tx_valid;
   logic               r_pkt_active;

   logic               w_start;
   logic               w_hs;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_pkt_last;
   logic               w_lat_done;
   logic               w_gap_done;

   // enable/aux only matter here, in IDLE; a packet in flight runs to its end
   assign w_start    = enable_i & aux_ready_i & ~fifo_empty_i &
                       (fifo_limit_i | (r_idle_cnt == IDLE_MAX));
   assign w_hs       = r_tx_valid & tx_ready_i;
   assign w_cnt_inc  = r_byte_cnt + 1'b1;
   assign w_pkt_last = (w_cnt_inc == PKT_MAX) | fifo_empty_i;
   assign w_lat_done = (r_lat_cnt == LAT_MAX);
   assign w_gap_done = (r_gap_cnt == GAP_LAST);

   assign tx_data_o    = r_tx_data;
   assign tx_valid_o   = r_tx_valid;
   assign pkt_active_o = r_pkt_active;
   assign byte_cnt_o   = r_byte_cnt;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (w_start) w_next_state = S_POP;
         // a FIFO that drained under us ends the packet without a read
         S_POP:       w_next_state = fifo_empty_i ? S_PKT_END : S_WAIT_DATA;
         S_WAIT_DATA: if (w_lat_done) w_next_state = S_SEND;
         S_SEND:      if (w_hs) w_next_state = w_pkt_last ? S_PKT_END : S_POP;
         S_PKT_END:   w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:       if (w_gap_done) w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // state-decoded strobes: single-cycle read pulse and packet-done pulse
   always_comb begin
      fifo_rd_o  = 1'b0;
      pkt_done_o = 1'b0;
      case (r_state)
         S_POP:     fifo_rd_o  = ~fifo_empty_i;
         S_PKT_END: pkt_done_o = 1'b1;
         default: ;
      endcase
   end

   // idle timer: counts non-empty below-limit cycles in IDLE, zero elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_idle_cnt <= '0;
      else if (r_state != S_IDLE)          r_idle_cnt <= '0;
      else if (fifo_empty_i)               r_idle_cnt <= '0;
      else if (!fifo_limit_i && (r_idle_cnt != IDLE_MAX))
                                           r_idle_cnt <= r_idle_cnt + 1'b1;
   end

   // read-latency counter: first WAIT_DATA cycle is count 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_lat_cnt <= '0;
      else if (r_state == S_POP)         r_lat_cnt <= LAT_W'(1);
      else if (r_state == S_WAIT_DATA && !w_lat_done)
                                         r_lat_cnt <= r_lat_cnt + 1'b1;
   end

   // inter-packet gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_gap_cnt <= '0;
      else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt + 1'b1;
      else                        r_gap_cnt <= '0;
   end

   // byte holding register, valid flag, byte count and packet-active flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_data    <= '0;
         r_tx_valid   <= 1'b0;
         r_byte_cnt   <= '0;
         r_pkt_active <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_byte_cnt   <= '0;
               r_pkt_active <= 1'b1;
            end
            S_WAIT_DATA: if (w_lat_done) begin
               r_tx_data  <= fifo_data_i;
               r_tx_valid <= 1'b1;
            end
            // valid is never withdrawn before the handshake
            S_SEND: if (w_hs) begin
               r_tx_valid <= 1'b0;
               r_byte_cnt <= w_cnt_inc;
            end
            S_PKT_END: r_pkt_active <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_tx_packetizer.sv
// tb_fifo_tx_packetizer: random-data bench with a queue-based FIFO model and a
// byte/packet scoreboard. One process drives stimulus and samples on negedge.
module tb_fifo_tx_packetizer;

   localparam int W       = 8;
   localparam int MAXP    = 58;
   localparam int IDLE_TO = 1000;
   localparam int LAT     = 2;
   localparam int GAP     = 16;
   localparam int CW      = $clog2(MAXP + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable_i;
   logic          fifo_empty_i;
   logic          fifo_limit_i;
   logic [W-1:0]  fifo_data_i;
   logic          fifo_rd_o;
   logic          aux_ready_i;
   logic [W-1:0]  tx_data_o;
   logic          tx_valid_o;
   logic          tx_ready_i;
   logic          pkt_active_o;
   logic          pkt_done_o;
   logic [CW-1:0] byte_cnt_o;

   fifo_tx_packetizer #(
      .WIDTH(W), .MAX_PKT(MAXP), .IDLE_TIMEOUT(IDLE_TO),
      .RD_LATENCY(LAT), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
      .fifo_empty_i(fifo_empty_i), .fifo_limit_i(fifo_limit_i),
      .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o),
      .aux_ready_i(aux_ready_i), .tx_data_o(tx_data_o),
      .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .pkt_active_o(pkt_active_o), .pkt_done_o(pkt_done_o),
      .byte_cnt_o(byte_cnt_o)
   );

   always #5 clk = ~clk;

   logic [W-1:0] fq[$];        // FIFO contents
   logic [W-1:0] exp_q[$];     // bytes still owed on the TX side, in order
   int           done_q[$];    // size of each finished packet
   logic [W-1:0] dpipe[LAT];   // read-data latency pipeline
   int  cyc, n_rd, hs_in_pkt, done_cyc, last_rd_cyc, rdy_mode, lim_lvl;
   int  n_chk, n_fail;
   bit  gap_pending, prev_stall, pend_rd, tput_chk;
   logic [W-1:0] prev_data;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   // per-cycle observation, taken on the falling edge
   task automatic monitor();
      logic [W-1:0] e;
      if (!rst_n) begin
         prev_stall = 0; hs_in_pkt = 0; gap_pending = 0; last_rd_cyc = -1; pend_rd = 0;
         return;
      end
      pend_rd = fifo_rd_o;
      if (fifo_rd_o) begin
         chk("rd_not_empty", fifo_empty_i, 0);
         chk("rd_in_pkt", pkt_active_o, 1);
         if (gap_pending) begin
            // PKT_END, GAP_CYCLES of gap, at least one IDLE cycle, then POP
            chk("gap_len_ok", (cyc - done_cyc) >= GAP + 2, 1);
            gap_pending = 0;
         end
         if (tput_chk && last_rd_cyc >= 0) chk("rd_spacing", cyc - last_rd_cyc, LAT + 2);
         last_rd_cyc = cyc;
         n_rd++;
      end
      if (prev_stall) begin
         chk("hold_valid", tx_valid_o, 1);
         chk("hold_data", tx_data_o, prev_data);
      end
      if (tx_valid_o && tx_ready_i) begin
         if (exp_q.size() == 0) chk("tx_extra_byte", exp_q.size(), 1);
         else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data_o, e);
         end
         hs_in_pkt++;
      end
      if (pkt_done_o) begin
         chk("byte_cnt_at_done", byte_cnt_o, hs_in_pkt);
         done_q.push_back(hs_in_pkt);
         hs_in_pkt = 0; done_cyc = cyc; gap_pending = 1; last_rd_cyc = -1;
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
   endtask

   // one clock: update FIFO model and ready just after the edge, observe on negedge
   task automatic step();
      @(posedge clk); #1;
      for (int i = LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
      if (pend_rd && fq.size() > 0) dpipe[0] = fq.pop_front();
      else                          dpipe[0] = W'($urandom);
      fifo_data_i  = dpipe[LAT-1];
      fifo_empty_i = (fq.size() == 0);
      fifo_limit_i = (fq.size() >= lim_lvl);
      case (rdy_mode)
         0:       tx_ready_i = 1'b1;
         1:       tx_ready_i = ($urandom_range(0, 3) != 0);
         default: tx_ready_i = 1'b0;
      endcase
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic wait_pkts(input string tag, input int n, input int maxc);
      int k = 0;
      while (done_q.size() < n && k < maxc) begin step(); k++; end
      chk(tag, done_q.size() >= n, 1);
   endtask

   task automatic wait_valid(input string tag, input int maxc);
      int k = 0;
      while (!tx_valid_o && k < maxc) begin step(); k++; end
      chk(tag, tx_valid_o, 1);
   endtask

   task automatic chk_outs_zero(input string pfx);
      chk({pfx, "_rd"}, fifo_rd_o, 0);
      chk({pfx, "_valid"}, tx_valid_o, 0);
      chk({pfx, "_data"}, tx_data_o, 0);
      chk({pfx, "_active"}, pkt_active_o, 0);
      chk({pfx, "_done"}, pkt_done_o, 0);
      chk({pfx, "_bcnt"}, byte_cnt_o, 0);
   endtask

   initial begin
      int n0, c0, k;
      n_chk = 0; n_fail = 0; cyc = 0; n_rd = 0; hs_in_pkt = 0; done_cyc = 0;
      last_rd_cyc = -1; gap_pending = 0; prev_stall = 0; pend_rd = 0; tput_chk = 0;
      prev_data = '0; rdy_mode = 0; lim_lvl = MAXP;
      for (int i = 0; i < LAT; i++) dpipe[i] = '0;
      rst_n = 1'b0; enable_i = 1'b0; aux_ready_i = 1'b0; fifo_empty_i = 1'b1;
      fifo_limit_i = 1'b0; fifo_data_i = '0; tx_ready_i = 1'b0;
      repeat (3) step();
      chk_outs_zero("reset");
      rst_n = 1'b1; enable_i = 1'b1; aux_ready_i = 1'b1;
      repeat (2) step();

      // T1: full packet 0x00..0x39 at full rate, then a second full packet after the gap
      tput_chk = 1; n0 = n_rd;
      for (int i = 0; i < MAXP; i++) push(W'(i));
      wait_pkts("t1_done", 1, 600);
      chk("t1_size", done_q[0], MAXP);
      chk("t1_rd_cnt", n_rd - n0, MAXP);
      for (int i = 0; i < MAXP; i++) push(W'($urandom));
      wait_pkts("t1b_done", 2, 600);
      chk("t1b_size", done_q[1], MAXP);
      tput_chk = 0;

      // T2: three bytes below limit are flushed only after the idle timeout
      rdy_mode = 1; c0 = cyc; n0 = n_rd;
      for (int i = 0; i < 3; i++) push(W'($urandom));
      k = 0;
      while (n_rd == n0 && k < IDLE_TO + GAP + 100) begin step(); k++; end
      chk("t2_start_seen", n_rd > n0, 1);
      chk("t2_not_early", (cyc - c0) > IDLE_TO, 1);
      chk("t2_not_late", (cyc - c0) <= IDLE_TO + GAP + 8, 1);
      wait_pkts("t2_done", 3, 200);
      chk("t2_size", done_q[2], 3);

      // T3: ten-cycle TX stall with a byte pending
      rdy_mode = 2; lim_lvl = 4;
      for (int i = 0; i < 5; i++) push(W'($urandom));
      wait_valid("t3_valid_seen", 60);
      n0 = n_rd;
      repeat (10) step();
      chk("t3_no_extra_rd", n_rd - n0, 0);
      chk("t3_valid_held", tx_valid_o, 1);
      rdy_mode = 0;
      wait_pkts("t3_done", 4, 200);
      chk("t3_size", done_q[3], 5);

      // T4: AUX not ready holds off a FIFO at its limit
      repeat (GAP + 5) step();
      aux_ready_i = 1'b0; lim_lvl = MAXP; n0 = n_rd;
      for (int i = 0; i < MAXP; i++) push(W'($urandom));
      repeat (30) step();
      chk("t4_no_rd", n_rd - n0, 0);
      chk("t4_not_active", pkt_active_o, 0);
      aux_ready_i = 1'b1; k = 0;
      while (n_rd == n0 && k < 10) begin step(); k++; end
      chk("t4_start_lat", k, 1);
      wait_pkts("t4_done", 5, 600);
      chk("t4_size", done_q[4], MAXP);

      // T5: 100 bytes split into 58 + 42 with random TX back-pressure
      rdy_mode = 1; lim_lvl = MAXP;
      for (int i = 0; i < 100; i++) push(W'($urandom));
      wait_pkts("t5_done", 7, 5000);
      chk("t5_size0", done_q[5], MAXP);
      chk("t5_size1", done_q[6], 100 - MAXP);
      chk("t5_no_loss", exp_q.size(), 0);
      chk("t5_fifo_drained", fq.size(), 0);

      // T6: reset while a byte is waiting in SEND drops that byte only
      repeat (GAP + 5) step();
      rdy_mode = 2; lim_lvl = 4;
      for (int i = 0; i < 6; i++) push(W'($urandom));
      wait_valid("t6_valid_seen", 60);
      rst_n = 1'b0;
      #1;
      chk_outs_zero("t6_rst");
      void'(exp_q.pop_front());
      repeat (3) step();
      rst_n = 1'b1; rdy_mode = 0;
      wait_pkts("t6_done", 8, 300);
      chk("t6_size", done_q[7], 5);
      chk("t6_no_loss", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
